// File: rtl/dma_oam_controller_pkg.sv
// Shared definitions for the OAM sprite DMA controller and the bus decoder.
// The state encodings and default addresses are kept here so both blocks use the same values.
package dma_oam_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] OAM_DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR        = 16'h2004;
  localparam int          OAM_XFER_LEN         = 256;

endpackage

// File: rtl/dma_oam_controller_parity.sv
// Rising-edge toggle flip-flop with synchronous reset.
// The DMA controller uses it as its get/put parity reference.
module flipflop_t_rise_1b (
  input  logic clk,
  input  logic srst,
  input  logic t_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      q_q <= 1'b0;
    end else if (t_i) begin
      q_q <= ~q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dma_oam_controller.sv
// NES OAM sprite DMA sequencer: halts the CPU and copies page $PP00-$PPFF into the PPU OAM data port.
// When idle, the CPU bus passes straight through to the system bus.
module dma_oam_controller
  import dma_oam_controller_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_TRIGGER_ADDR,
  parameter logic [15:0] TARGET_ADDR  = OAM_DATA_ADDR,
  parameter int          XFER_LEN     = OAM_XFER_LEN
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_write,
  input  logic [7:0]  bus_data_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_write,
  output logic        cpu_rdy,
  output logic        dma_active
);

  localparam logic [7:0] LAST_INDEX = 8'(XFER_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] data_q, data_d;
  logic       parity_q;

  // Free-running parity: 0 marks a get cycle, 1 a put cycle.
  flipflop_t_rise_1b u_parity (
    .clk  (clock),
    .srst (reset),
    .t_i  (1'b1),
    .q_o  (parity_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      page_q  <= 8'h00;
      index_q <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    index_d      = index_q;
    data_d       = data_q;
    bus_addr     = cpu_addr;
    bus_data_out = cpu_data_out;
    bus_write    = 1'b0;
    cpu_rdy      = 1'b0;
    dma_active   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        bus_write  = cpu_write;
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        if (cpu_write && (cpu_addr == TRIGGER_ADDR)) begin
          page_d  = cpu_data_out;
          index_d = 8'h00;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        // A get-parity halt needs one extra put cycle so every READ lands on a get cycle.
        state_d = parity_q ? ST_READ : ST_ALIGN;
      end
      ST_ALIGN: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        bus_addr = {page_q, index_q};
        data_d   = bus_data_in;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        bus_addr     = TARGET_ADDR;
        bus_data_out = data_q;
        bus_write    = 1'b1;
        index_d      = index_q + 8'd1;
        state_d      = (index_q == LAST_INDEX) ? ST_IDLE : ST_READ;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reads belong on get cycles and writes on put cycles; anything else means the sequencer slipped.
  assert property (@(posedge clock) disable iff (reset)
    !(((state_q == ST_READ) && parity_q) || ((state_q == ST_WRITE) && !parity_q)));

endmodule

// File: tb/tb_dma_oam_controller.sv
// Directed bench for dma_oam_controller: pass-through, non-trigger accesses, both halt parities,
// reset mid-transfer and reset racing a trigger. Source memory returns low address byte XOR 8'h5A.
module tb_dma_oam_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_write;
  logic [7:0]  bus_data_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_write;
  logic        cpu_rdy;
  logic        dma_active;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          stall_cnt, rd_cnt, wr_cnt, bad_wr, pre_rd, flag_err;
  logic [15:0] first_rd, last_rd;
  logic        first_par;
  logic [7:0]  wr_data [0:255];

  dma_oam_controller dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_write    (cpu_write),
    .bus_data_in  (bus_data_in),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_write    (bus_write),
    .cpu_rdy      (cpu_rdy),
    .dma_active   (dma_active)
  );

  always #5 clock = ~clock;

  assign bus_data_in = bus_addr[7:0] ^ 8'h5A;

  // Expected parity of the current cycle: 0 in the first cycle after reset, then alternating.
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clock) begin
    if (!cpu_rdy) stall_cnt = stall_cnt + 1;
    if (dma_active == cpu_rdy) flag_err = flag_err + 1;
    if (dma_active && !bus_write && (bus_addr != cpu_addr)) begin
      if (rd_cnt == 0) begin
        first_rd  = bus_addr;
        first_par = cyc[0];
        pre_rd    = stall_cnt - 1;
      end
      last_rd = bus_addr;
      rd_cnt  = rd_cnt + 1;
    end
    if (dma_active && bus_write) begin
      if (bus_addr == 16'h2004) begin
        if (wr_cnt < 256) wr_data[wr_cnt] = bus_data_out;
        wr_cnt = wr_cnt + 1;
      end else begin
        bad_wr = bad_wr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; bad_wr = 0; pre_rd = 0; flag_err = 0;
    first_rd = 16'h0; last_rd = 16'h0; first_par = 1'b0;
  endtask

  // Issue the trigger so the HALT cycle lands on the requested parity, then keep
  // hammering the trigger address for a while to prove it is ignored during DMA.
  task automatic start_dma(input logic [7:0] page, input logic halt_par);
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (cyc[0] != halt_par) break;
    end
    cpu_addr = 16'h4014; cpu_data_out = page; cpu_write = 1'b1;
    @(negedge clock); #1;
    chk("trig_pass_addr", bus_addr, 16'h4014);
    chk("trig_pass_wr", bus_write, 1'b1);
    chk("trig_rdy", cpu_rdy, 1'b1);
    @(posedge clock); #1;
    cpu_data_out = 8'h07;
    repeat (20) @(posedge clock);
    #1;
    cpu_write = 1'b0; cpu_addr = 16'hC000; cpu_data_out = 8'h00;
  endtask

  task automatic finish_dma(input logic [7:0] page, input logic halt_par);
    int err;
    int guard;
    guard = 0;
    while (!cpu_rdy && guard < 1000) begin
      @(negedge clock); #1;
      guard++;
    end
    if (guard >= 1000) chk("done_timeout", 1, 0);
    $display("[TB] dma page %02h halt_par %0d: stall %0d reads %0d writes %0d",
             page, halt_par, stall_cnt, rd_cnt, wr_cnt);
    chk("stall_cycles", stall_cnt, halt_par ? 513 : 514);
    chk("pre_read_cycles", pre_rd, halt_par ? 1 : 2);
    chk("first_read_parity", first_par, 1'b0);
    chk("read_count", rd_cnt, 256);
    chk("first_read_addr", first_rd, {page, 8'h00});
    chk("last_read_addr", last_rd, {page, 8'hFF});
    chk("write_count", wr_cnt, 256);
    chk("stray_writes", bad_wr, 0);
    chk("rdy_vs_active", flag_err, 0);
    chk("wdata_0", wr_data[0], 8'h5A);
    chk("wdata_1", wr_data[1], 8'h5B);
    chk("wdata_255", wr_data[255], 8'hA5);
    err = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_data[i] !== (8'(i) ^ 8'h5A)) err++;
    end
    chk("wdata_all", err, 0);
    repeat (3) begin
      @(negedge clock); #1;
    end
    chk("no_restart", stall_cnt, halt_par ? 513 : 514);
  endtask

  initial begin
    int low;
    int guard;
    reset = 1'b1; cpu_addr = 16'h5555; cpu_data_out = 8'h33; cpu_write = 1'b0;
    clear_mon();
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_rdy", cpu_rdy, 1'b1);
    chk("rst_active", dma_active, 1'b0);
    chk("rst_pass_addr", bus_addr, 16'h5555);
    @(posedge clock); #1;
    reset = 1'b0;

    // Idle pass-through of an ordinary write.
    cpu_addr = 16'h1234; cpu_data_out = 8'hAB; cpu_write = 1'b1;
    @(negedge clock); #1;
    chk("pass_addr", bus_addr, 16'h1234);
    chk("pass_wr", bus_write, 1'b1);
    chk("pass_data", bus_data_out, 8'hAB);
    chk("pass_rdy", cpu_rdy, 1'b1);
    @(posedge clock); #1;
    cpu_write = 1'b0;
    @(negedge clock); #1;
    chk("pass_rd_wr", bus_write, 1'b0);
    chk("pass_rdy_after", cpu_rdy, 1'b1);

    // Neighbouring address write and a read of the trigger address must not start DMA.
    @(posedge clock); #1;
    cpu_addr = 16'h4015; cpu_data_out = 8'h02; cpu_write = 1'b1;
    @(posedge clock); #1;
    cpu_addr = 16'h4014; cpu_write = 1'b0;
    @(posedge clock); #1;
    cpu_addr = 16'hC000;
    low = 0;
    repeat (5) begin
      @(negedge clock); #1;
      if (!cpu_rdy || dma_active) low++;
    end
    chk("no_trigger", low, 0);
    $display("[TB] non-trigger accesses: halted cycles %0d", low);

    start_dma(8'h02, 1'b1);
    finish_dma(8'h02, 1'b1);
    start_dma(8'h02, 1'b0);
    finish_dma(8'h02, 1'b0);

    // Reset after the 40th write, with a trigger presented in the same reset cycle.
    start_dma(8'h02, 1'b1);
    guard = 0;
    while (wr_cnt < 40 && guard < 1000) begin
      @(negedge clock); #1;
      guard++;
    end
    if (guard >= 1000) chk("w40_timeout", 1, 0);
    @(posedge clock); #1;
    reset = 1'b1; cpu_addr = 16'h4014; cpu_data_out = 8'h03; cpu_write = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; cpu_addr = 16'hC000; cpu_write = 1'b0;
    @(negedge clock); #1;
    chk("midrst_rdy", cpu_rdy, 1'b1);
    chk("midrst_active", dma_active, 1'b0);
    chk("midrst_pass", bus_addr, 16'hC000);
    low = 0;
    repeat (4) begin
      @(negedge clock); #1;
      if (!cpu_rdy) low++;
    end
    chk("midrst_stays_idle", low, 0);
    chk("midrst_writes", wr_cnt, 40);
    $display("[TB] reset after %0d writes, halted cycles after reset %0d", wr_cnt, low);

    start_dma(8'h03, 1'b1);
    finish_dma(8'h03, 1'b1);
    start_dma(8'h03, 1'b0);
    finish_dma(8'h03, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
